// File: rtl/main_memory_responder.sv
// Main-memory end of the cache refill/write-back interface: fixed access latency, then a
// critical-word-first line burst out (refill) or in (write-back), one word per cycle.
module main_memory_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned BASE_W = ADDR_W - OFF_W;
    localparam int unsigned BEAT_W = OFF_W + 1;
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(LINE_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRburst,
        StWburst
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic                req_ready_q, req_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_last_q, rd_last_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   word_idx;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // Line base is fixed for the whole burst; only the offset wraps.
    assign word_idx = {base_q, off_q};

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        base_d    = base_q;
        off_d     = off_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        rd_data_d = '0;
        rd_last_d = 1'b0;
        wr_done_d = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    we_d    = req_we;
                    base_d  = req_addr[ADDR_W-1:OFF_W];
                    off_d   = req_addr[OFF_W-1:0];
                    beat_d  = '0;
                    lat_d   = LAT_LOAD;
                end
            end
            StWait: begin
                if (lat_q == '0) begin
                    if (we_q) begin
                        state_d = StWburst;
                    end else begin
                        // First read beat is produced on the edge that leaves WAIT.
                        state_d   = StRburst;
                        rd_data_d = mem[word_idx];
                        rd_last_d = (beat_q == BEAT_LAST);
                        off_d     = off_q + OFF_W'(1);
                        beat_d    = beat_q + BEAT_W'(1);
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StRburst: begin
                if (beat_q == BEAT_FULL) begin
                    state_d = StIdle;
                    beat_d  = '0;
                end else begin
                    rd_data_d = mem[word_idx];
                    rd_last_d = (beat_q == BEAT_LAST);
                    off_d     = off_q + OFF_W'(1);
                    beat_d    = beat_q + BEAT_W'(1);
                end
            end
            StWburst: begin
                if (wr_valid) begin
                    mem_we = 1'b1;
                    off_d  = off_q + OFF_W'(1);
                    if (beat_q == BEAT_LAST) begin
                        state_d   = StIdle;
                        wr_done_d = 1'b1;
                        beat_d    = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        req_ready_d = (state_d == StIdle);
        wr_ready_d  = (state_d == StWburst);
        rd_valid_d  = (state_d == StRburst);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            base_q      <= '0;
            off_q       <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            base_q      <= base_d;
            off_q       <= off_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            wr_done_q   <= wr_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_data;
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign wr_done   = wr_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Backing-store responder on the memory side of the cache controller. It accepts line-refill and line-write-back requests from the controller, waits a fixed access latency, then streams a full cache line out (reads) or absorbs a full line in (write-backs) one word per cycle. Storage is a word-addressed array sized to the full address space. The block is the main-memory end of the interface that the cache controller initiates.

## Interface

Parameters:
- `ADDR_W`, default 10: word-address width; storage holds 2^ADDR_W words.
- `DATA_W`, default 32: word width.
- `LINE_WORDS`, default 4: words per cache line; must be a power of two, at least 2.
- `LATENCY`, default 3: cycles from request acceptance to the first data beat or first `wr_ready`; must be at least 1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: responder idle; a request is accepted when `req_valid && req_ready`.
- `req_we`, input, 1: 1 means line write-back, 0 means line read (refill).
- `req_addr`, input, ADDR_W: word address; the upper bits select the line and the low log2(LINE_WORDS) bits select the first word.
- `wr_valid`, input, 1: write beat present.
- `wr_ready`, output, 1: responder accepting write beats.
- `wr_data`, input, DATA_W: write beat data.
- `wr_done`, output, 1: one-cycle pulse when a write-back completes.
- `rd_valid`, output, 1: read beat valid. There is no backpressure; the initiator must sink every beat.
- `rd_data`, output, DATA_W: read beat data.
- `rd_last`, output, 1: marks the final beat of a read burst.

## Operation

- **States:** IDLE, WAIT, RBURST, WBURST.
- **IDLE:** `req_ready` is 1.
  - On acceptance, latch `req_we` and `req_addr`, load the latency counter, and go to WAIT.
  - `req_valid` is ignored in every other state. The initiator holds the request until it is accepted.
- **WAIT:** counts LATENCY cycles. At the end it goes to RBURST if the latched `req_we` is 0, otherwise to WBURST.
- **Beat offset:** starts at the latched low address bits and increments modulo LINE_WORDS (critical word first, wrapping within the line). The line base never changes during a burst.
- **RBURST:**
  - Outputs one word per cycle for exactly LINE_WORDS consecutive cycles.
  - `rd_data` is the storage word at line base plus current offset.
  - `rd_last` is 1 on the LINE_WORDS-th beat; the state then returns to IDLE.
- **WBURST:**
  - `wr_ready` is 1.
  - Each cycle with `wr_valid` 1 writes `wr_data` to line base plus offset and advances the offset and the beat counter.
  - A cycle with `wr_valid` 0 is a stall and has no effect.
  - After the LINE_WORDS-th accepted beat, go to IDLE and assert `wr_done` in that first IDLE cycle.
- **Storage:**
  - Contents are not affected by reset.
  - The simulation initial value is all zeros.
  - A write is visible to any read request accepted at or after the `wr_done` cycle.
- **Reset values:** `req_ready`=1 (IDLE), and `wr_ready`, `wr_done`, `rd_valid`, `rd_last`, `rd_data` are all 0. All counters and latches are cleared.
- **Reset mid-operation:** the FSM returns to IDLE immediately. A partial burst is abandoned: beats already written remain in storage, and no `wr_done` or `rd_last` is produced.

## Timing

- **Request accept:** a request accepted at edge N puts the state in WAIT from N to N+LATENCY.
- **First beat:** the first `rd_valid` beat, or the first `wr_ready`=1 cycle, is the cycle after edge N+LATENCY.
- **Read occupancy:** exactly LATENCY+LINE_WORDS cycles. `req_ready` returns to 1 in the cycle after `rd_last`.
- **Write occupancy:** LATENCY + LINE_WORDS + (stall cycles) cycles, plus the `wr_done` cycle, in which `req_ready` is already 1. A request may be accepted in the `wr_done` cycle.
- **Registered outputs:** all outputs are registered. `rd_data` changes only together with `rd_valid` and holds 0 when `rd_valid` is 0.
- **`wr_ready` deassertion:** `wr_ready` falls in the cycle after the final accepted beat, never earlier.

## Test plan

Scenarios 1–5 use LATENCY=3 and LINE_WORDS=4.

1. **Write then read back:** write-back to addr 128 with beats 69, 70, 71, 72 and no stalls. Then read addr 128.
   - `wr_ready` rises 3 cycles after acceptance.
   - `wr_done` pulses in the cycle after beat 4.
   - The read returns 69, 70, 71, 72 on 4 consecutive cycles, with `rd_last` on 72.
2. **Wrap:** after scenario 1, read addr 130.
   - Returns 71, 72, 69, 70, with `rd_last` on 70.
3. **Write stall:** write-back to addr 564 with 420, 421, then `wr_valid`=0 for 2 cycles, then 422, 423.
   - `wr_ready` stays 1 throughout.
   - Exactly 4 words are written.
   - `wr_done` arrives 2 cycles later than in the no-stall case.
   - A read of addr 564 returns 420..423.
4. **Busy:** `req_valid` is held with a read of addr 0 while a burst is in progress.
   - `req_ready` stays 0 and no state change occurs.
   - The request is accepted in the first `req_ready`=1 cycle.
   - Returns 0, 0, 0, 0 from unwritten storage.
5. **Reset mid-read:** assert `reset_n`=0 after 2 beats of a read of addr 128.
   - `rd_valid` goes to 0 immediately.
   - `req_ready` is 1 after release.
   - A re-read of addr 128 returns 69..72.
6. **Read-after-write in the `wr_done` cycle:** issue a read of the just-written line in the `wr_done` cycle.
   - The request is accepted.
   - The new data is returned.
